// File: rtl/hash_key_packer.sv
// Buffers a memcache key byte stream and replays it as little-endian 12-byte
// Jenkins hash blocks tagged with length/remaining. Optional m_ovf port: KEY_OVF_FLAG_EN.
module hash_key_packer #(
    parameter int unsigned MAXLEN = 250,
    parameter int unsigned NBLK   = 21
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_k0,
    output logic [31:0] m_k1,
    output logic [31:0] m_k2,
    output logic [7:0]  m_len,
    output logic [7:0]  m_rem,
    output logic        m_first,
    output logic        m_last
`ifdef KEY_OVF_FLAG_EN
    ,
    output logic        m_ovf
`endif
);

    localparam int unsigned BLK_BYTES = 12;
    localparam int unsigned BLK_W     = 8 * BLK_BYTES;
    localparam int unsigned IDX_W     = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic {FILL, EMIT} state_t;

    state_t             state;
    logic [7:0]         cnt;
    logic [IDX_W-1:0]   idx;
    logic [BLK_W-1:0]   blk_mem [NBLK];
`ifdef KEY_OVF_FLAG_EN
    logic               ovf_q;
`endif

    logic               accept_c;
    logic               full_c;
    logic               wr_en_c;
    logic [IDX_W-1:0]   wr_blk_c;
    logic [3:0]         lane_c;
    logic [BLK_W-1:0]   blk_wr_c;
    logic [BLK_W-1:0]   blk0_c;
    logic [BLK_W-1:0]   nxt_blk_c;
    logic [7:0]         len_next_c;
    logic [7:0]         rem_next_c;

    // Write path: lane 0 starts a fresh block, so stale bytes never leak into a new key
    always_comb begin
        accept_c   = s_valid & s_ready & (state == FILL);
        full_c     = (cnt == 8'(MAXLEN));
        wr_en_c    = accept_c & ~full_c & ~RST;
        wr_blk_c   = IDX_W'(cnt / 8'(BLK_BYTES));
        lane_c     = 4'(cnt % 8'(BLK_BYTES));
        blk_wr_c   = (lane_c == 4'd0) ? '0 : blk_mem[wr_blk_c];
        blk_wr_c[8*lane_c +: 8] = s_data;
        blk0_c     = (wr_en_c && (wr_blk_c == '0)) ? blk_wr_c : blk_mem[0];
        nxt_blk_c  = blk_mem[idx + IDX_W'(1)];
        len_next_c = full_c ? 8'(MAXLEN) : cnt + 8'd1;
        rem_next_c = m_rem - 8'(BLK_BYTES);
    end

    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            blk_mem[wr_blk_c] <= blk_wr_c;
        end
    end

    // Control FSM with registered handshake and block outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FILL;
            cnt     <= '0;
            idx     <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_k0    <= '0;
            m_k1    <= '0;
            m_k2    <= '0;
            m_len   <= '0;
            m_rem   <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
`ifdef KEY_OVF_FLAG_EN
            ovf_q   <= 1'b0;
            m_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (accept_c) begin
                        if (full_c) begin
`ifdef KEY_OVF_FLAG_EN
                            ovf_q <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                        if (s_last) begin
                            state   <= EMIT;
                            cnt     <= '0;
                            idx     <= '0;
                            s_ready <= 1'b0;
                            m_valid <= 1'b1;
                            m_k0    <= blk0_c[31:0];
                            m_k1    <= blk0_c[63:32];
                            m_k2    <= blk0_c[95:64];
                            m_len   <= len_next_c;
                            m_rem   <= len_next_c;
                            m_first <= 1'b1;
                            m_last  <= (len_next_c <= 8'(BLK_BYTES));
`ifdef KEY_OVF_FLAG_EN
                            m_ovf   <= ovf_q | full_c;
`endif
                        end
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        if (m_last) begin
                            state   <= FILL;
                            m_valid <= 1'b0;
                            s_ready <= 1'b1;
                            m_first <= 1'b0;
                            m_last  <= 1'b0;
`ifdef KEY_OVF_FLAG_EN
                            ovf_q   <= 1'b0;
                            m_ovf   <= 1'b0;
`endif
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            m_k0    <= nxt_blk_c[31:0];
                            m_k1    <= nxt_blk_c[63:32];
                            m_k2    <= nxt_blk_c[95:64];
                            m_rem   <= rem_next_c;
                            m_first <= 1'b0;
                            m_last  <= (rem_next_c <= 8'(BLK_BYTES));
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: doc/hash_key_packer.md
Name: hash_key_packer

Overview:
Producer side of the Jenkins hash key interface. It accepts a memcache key as a byte stream from the protocol parser and buffers the whole key, because the hash needs the total length before the first block. It then emits the key as little-endian 12-byte blocks (k0/k1/k2), each tagged with the total length and the bytes remaining, which are the values the hash pipeline consumes. The hash engine instance sits directly downstream.

Parameters:
MAXLEN, 250, maximum key length in bytes; must be at most 255; longer keys are truncated.
NBLK, 21, block buffer depth; must equal ceil(MAXLEN/12).

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
s_valid  input  1  key byte valid
s_ready  output  1  packer can accept a byte
s_data  input  8  key byte, first byte first
s_last  input  1  final byte of the key
m_valid  output  1  block valid
m_ready  input  1  hash side accepts block
m_k0  output  32  key bytes 0-3 of block (byte 0 in bits 7:0)
m_k1  output  32  key bytes 4-7 of block
m_k2  output  32  key bytes 8-11 of block
m_len  output  8  total key length in bytes
m_rem  output  8  bytes remaining including this block (len - 12*idx)
m_first  output  1  first block of key
m_last  output  1  last block of key
m_ovf  output  1  key was truncated (only with KEY_OVF_FLAG_EN)

Behaviour:
- One clock CLK; reset RST is synchronous and active-high.
- Reset values: s_ready=0, m_valid=0, m_k0/k1/k2=0, m_len=0, m_rem=0, m_first=0, m_last=0, m_ovf=0. The state machine resets to FILL with the byte count at 0. s_ready is registered and rises the cycle after RST deasserts.
- Reset mid-operation: the partial or pending key is discarded. No block is emitted for it.
- FILL state:
  - s_ready=1 and m_valid=0.
  - A byte is accepted on s_valid&s_ready and written to block cnt/12, lane cnt%12.
  - Lanes 0-3 map to m_k0, 4-7 to m_k1, 8-11 to m_k2, little-endian within each word.
  - Every lane of a block reads as zero unless written during the current key. Clear each block on first write, or clear all blocks on entry to FILL.
  - cnt is 8-bit.
- Overflow: bytes accepted while cnt==MAXLEN are dropped. cnt saturates at MAXLEN and the internal ovf flag is set.
- FILL to EMIT transition:
  - Triggered by an accepted byte with s_last=1.
  - len = min(cnt+1, MAXLEN), idx=0, s_ready drops the next cycle.
  - m_valid rises the cycle after s_last is accepted (1-cycle latency).
- EMIT state:
  - s_ready=0 and m_valid=1.
  - Outputs reflect block idx: m_len=len, m_rem=len-12*idx, m_first=(idx==0), m_last=(m_rem<=12).
- Block handshake: a block transfers on m_valid&m_ready. All m_* outputs hold stable while m_valid&!m_ready.
  - Transfer with m_last=0: idx increments and the next block is presented the following cycle. There are no bubbles under continuous m_ready.
  - Transfer with m_last=1: return to FILL. m_valid=0 and s_ready=1 the next cycle, and the ovf flag clears.
- Zero-length keys cannot occur, since every key has at least one byte with s_last.
- Exactly ceil(len/12) blocks are emitted per key.
- Unused tail lanes of the last block are 0, which matches the hash final-mix masking.
- Arithmetic: m_rem is computed mod 256. It never underflows because idx < ceil(len/12).
- Single buffered: a new key is not accepted until the last block of the previous key has transferred.

Optional Feature:
KEY_OVF_FLAG_EN
- Defined: port m_ovf exists. It equals the ovf flag throughout EMIT of a truncated key, is 0 otherwise, and resets to 0.
- Undefined: port m_ovf is absent. Truncation to MAXLEN is silent, with identical blocks and timing.

Test Plan:
- Key 0x61,0x62,0x63 (last on 0x63), m_ready=1.
  - One block with m_k0=0x00636261, m_k1=0, m_k2=0.
  - m_len=3, m_rem=3, m_first=m_last=1.
  - m_valid asserted exactly 1 cycle after the last byte.
- Bytes 0x00..0x0B: one block with m_k0=0x03020100, m_k1=0x07060504, m_k2=0x0B0A0908, m_len=12, m_rem=12, first=last=1.
- Bytes 0x00..0x0C:
  - Block 0 (rem=13, first=1, last=0).
  - Block 1 (k0=0x0000000C, k1=k2=0, rem=1, last=1).
  - The two blocks are on consecutive cycles.
- 13-byte key with m_ready=0 for 5 cycles: block 0 outputs are held unchanged for those cycles, s_ready=0 throughout EMIT, and s_ready=1 the cycle after the block 1 transfer.
- 260-byte key:
  - 21 blocks with m_len=250, last block rem=10.
  - Bytes 250-259 do not appear; tail lanes 10-11 are zero.
  - m_ovf=1 with the macro defined.
  - A following 3-byte key gives m_ovf=0.
- RST pulse after 7 bytes of a key: s_ready=0 during RST and no block is emitted. A following key 0x41 gives one block with k0=0x00000041, len=1.
